// File: rtl/pulse_id_sequencer.sv
// pulse_id_sequencer: captures pulse_identifier results into a show-ahead FIFO
// and runs the identifier's reset handshake with a watchdog on the acknowledge.
// Optional statistics (drop_count, frame_count, wd_error) exist only when the
// PULSE_SEQ_STATS_EN macro is defined; otherwise those outputs are tied to 0.
module pulse_id_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int WATCHDOG_TICKS = 7200
) (
  input  logic                          clk_72MHz,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          pid_ready,
  input  logic [16:0]                   pid_pulse_id_0,
  input  logic [16:0]                   pid_pulse_id_1,
  input  logic [16:0]                   pid_pulse_id_2,
  input  logic [16:0]                   pid_polynomial,
  input  logic [23:0]                   sys_ts,
  output logic                          pid_reset,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [16:0]                   out_pulse_id_0,
  output logic [16:0]                   out_pulse_id_1,
  output logic [16:0]                   out_pulse_id_2,
  output logic [16:0]                   out_polynomial,
  output logic [23:0]                   out_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count,
  output logic [15:0]                   frame_count,
  output logic                          wd_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 17 * 4 + 24;
  localparam int WW = $clog2(WATCHDOG_TICKS + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_TICKS - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK, RELEASE} state_t;

  state_t        state, next_state;
  logic [EW-1:0] snapshot;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [WW-1:0] wd_cnt;
  logic          fifo_full, push, pop, ack_timeout;

  assign fifo_full   = (level == LEVEL_FULL);
  assign out_valid   = (level != '0);
  assign pop         = out_valid && out_ready;
  assign push        = (state == CAPTURE);
  assign ack_timeout = (state == ACK) && pid_ready && (wd_cnt == WD_LAST);
  assign fifo_level  = level;
  assign {out_pulse_id_0, out_pulse_id_1, out_pulse_id_2, out_polynomial, out_ts} = mem[rd_ptr];

  // Next-state decision: capture only with room and enable, otherwise go straight to acknowledge
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pid_ready) next_state = (enable && !fifo_full) ? CAPTURE : ACK;
      CAPTURE: next_state = ACK;
      ACK:     if (!pid_ready || ack_timeout) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; pid_reset is dropped on the edge that leaves ACK so RELEASE is always low
  always_ff @(posedge clk_72MHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pid_reset <= 1'b0;
    end else begin
      state     <= next_state;
      pid_reset <= (state == ACK) && (next_state == ACK);
    end
  end

  // Watchdog counts ACK cycles from zero on every entry and holds at its last value
  always_ff @(posedge clk_72MHz or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state != ACK) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_LAST) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Snapshot the identifier result and timestamp on the edge ready is seen in IDLE
  always_ff @(posedge clk_72MHz or posedge reset) begin
    if (reset) begin
      snapshot <= '0;
    end else if (state == IDLE && pid_ready) begin
      snapshot <= {pid_pulse_id_0, pid_pulse_id_1, pid_pulse_id_2, pid_polynomial, sys_ts};
    end
  end

  // Result FIFO storage and pointers; cleared on reset so the head reads as zero
  always_ff @(posedge clk_72MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= snapshot;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy tracks push/pop; simultaneous push and pop leave it unchanged
  always_ff @(posedge clk_72MHz or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef PULSE_SEQ_STATS_EN
  // Statistics: saturating drop counter, wrapping frame counter, sticky watchdog flag
  always_ff @(posedge clk_72MHz or posedge reset) begin
    if (reset) begin
      drop_count  <= '0;
      frame_count <= '0;
      wd_error    <= 1'b0;
    end else begin
      if (state == IDLE && pid_ready && enable && fifo_full && drop_count != 8'hFF)
        drop_count <= drop_count + 1'b1;
      if (push) frame_count <= frame_count + 1'b1;
      if (ack_timeout) wd_error <= 1'b1;
    end
  end
`else
  assign drop_count  = '0;
  assign frame_count = '0;
  assign wd_error    = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_id_sequencer.sv
// Testbench for pulse_id_sequencer: directed results with a scoreboard queue
// checked by an independent pop monitor.
`timescale 1ns/1ps
module tb_pulse_id_sequencer;

  localparam int FIFO_DEPTH     = 4;
  localparam int WATCHDOG_TICKS = 7200;
`ifdef PULSE_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_72MHz = 1'b0;
  logic        reset, enable, pid_ready, out_ready;
  logic [16:0] pid_pulse_id_0, pid_pulse_id_1, pid_pulse_id_2, pid_polynomial;
  logic [23:0] sys_ts;
  logic        pid_reset, out_valid, wd_error;
  logic [16:0] out_pulse_id_0, out_pulse_id_1, out_pulse_id_2, out_polynomial;
  logic [23:0] out_ts;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;
  logic [15:0] frame_count;

  logic [91:0] sb[$];
  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  int exp_frame = 0;
  int exp_wd = 0;

  pulse_id_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .WATCHDOG_TICKS(WATCHDOG_TICKS)) dut (
    .clk_72MHz(clk_72MHz), .reset(reset), .enable(enable), .pid_ready(pid_ready),
    .pid_pulse_id_0(pid_pulse_id_0), .pid_pulse_id_1(pid_pulse_id_1),
    .pid_pulse_id_2(pid_pulse_id_2), .pid_polynomial(pid_polynomial), .sys_ts(sys_ts),
    .pid_reset(pid_reset), .out_valid(out_valid), .out_ready(out_ready),
    .out_pulse_id_0(out_pulse_id_0), .out_pulse_id_1(out_pulse_id_1),
    .out_pulse_id_2(out_pulse_id_2), .out_polynomial(out_polynomial), .out_ts(out_ts),
    .fifo_level(fifo_level), .drop_count(drop_count), .frame_count(frame_count),
    .wd_error(wd_error)
  );

  always #7 clk_72MHz = ~clk_72MHz;

  // Global time limit so the bench can never hang
  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got still running, expected finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input logic [91:0] act, input logic [91:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, "_drop"},  longint'(drop_count),  STATS ? longint'(exp_drop)  : 0);
    checkOutput({tag, "_frame"}, longint'(frame_count), STATS ? longint'(exp_frame) : 0);
    checkOutput({tag, "_wd"},    longint'(wd_error),    STATS ? longint'(exp_wd)    : 0);
  endtask

  // Monitor: every pop the DUT will take on the next edge must match the queue head
  always @(negedge clk_72MHz) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pop", 1, 0);
      end else begin
        checkData("pop_data", {out_pulse_id_0, out_pulse_id_1, out_pulse_id_2, out_polynomial, out_ts},
                  sb.pop_front());
      end
    end
  end

  // One result handshake; the expected outcome is decided from the model occupancy
  task automatic applyStimulus(input logic [16:0] a, input logic [16:0] b, input logic [16:0] c,
                               input logic [16:0] p, input logic [23:0] ts, input bit pop_same_edge);
    bit will_push;
    int lat;
    int width;
    will_push = enable && (sb.size() < FIFO_DEPTH);
    if (will_push) begin
      sb.push_back({a, b, c, p, ts});
      exp_frame = (exp_frame + 1) % 65536;
    end else if (enable && exp_drop < 255) begin
      exp_drop++;
    end
    pid_pulse_id_0 = a; pid_pulse_id_1 = b; pid_pulse_id_2 = c; pid_polynomial = p; sys_ts = ts;
    pid_ready = 1'b1;
    if (pop_same_edge) out_ready = 1'b1;
    lat = 0;
    while (!pid_reset && lat < 20) begin
      @(posedge clk_72MHz); #1;
      lat++;
      out_ready = out_ready && !pop_same_edge;
    end
    checkOutput("ack_latency", lat, will_push ? 3 : 2);
    pid_ready = 1'b0;
    width = 0;
    while (pid_reset && width < 20) begin
      @(posedge clk_72MHz); #1;
      width++;
    end
    checkOutput("ack_width", width, 1);
    @(posedge clk_72MHz); #1;
  endtask

  task automatic drainFifo();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 20) begin
      @(posedge clk_72MHz); #1;
      n++;
    end
    out_ready = 1'b0;
    checkOutput("drain_level", longint'(fifo_level), 0);
    checkOutput("drain_sb_empty", sb.size(), 0);
  endtask

  initial begin
    int lat, width;
    reset = 1'b1; enable = 1'b1; pid_ready = 1'b0; out_ready = 1'b0;
    pid_pulse_id_0 = '0; pid_pulse_id_1 = '0; pid_pulse_id_2 = '0; pid_polynomial = '0; sys_ts = '0;
    repeat (3) @(posedge clk_72MHz);
    #1;
    checkOutput("rst_pid_reset", longint'(pid_reset), 0);
    checkOutput("rst_out_valid", longint'(out_valid), 0);
    checkOutput("rst_level", longint'(fifo_level), 0);
    checkOutput("rst_out_id0", longint'(out_pulse_id_0), 0);
    checkStats("rst");
    reset = 1'b0;
    @(posedge clk_72MHz); #1;

    $display("[TB] single result");
    applyStimulus(17'd100, 17'd250, 17'd400, 17'h0D5A5, 24'h001234, 1'b0);
    checkOutput("t1_valid", longint'(out_valid), 1);
    checkOutput("t1_ts", longint'(out_ts), 24'h001234);
    checkOutput("t1_level", longint'(fifo_level), 1);
    checkStats("t1");
    drainFifo();

    $display("[TB] five results without popping");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(17'(i + 1), 17'(i * 3 + 7), 17'(1000 - i), 17'h1F000 + 17'(i), 24'hA00000 + 24'(i), 1'b0);
      checkOutput("t2_level", longint'(fifo_level), sb.size());
    end
    checkOutput("t2_full_level", longint'(fifo_level), 4);
    checkStats("t2");
    drainFifo();

    $display("[TB] disabled result and pop on empty");
    enable = 1'b0;
    applyStimulus(17'd5, 17'd6, 17'd7, 17'd8, 24'h000009, 1'b0);
    enable = 1'b1;
    checkOutput("t3_level", longint'(fifo_level), 0);
    checkStats("t3");
    out_ready = 1'b1;
    repeat (2) @(posedge clk_72MHz);
    #1;
    out_ready = 1'b0;
    checkOutput("t3_empty_pop_level", longint'(fifo_level), 0);
    checkOutput("t3_empty_pop_valid", longint'(out_valid), 0);

    $display("[TB] watchdog");
    sb.push_back({17'd11, 17'd22, 17'd33, 17'h00044, 24'h555555});
    exp_frame++;
    pid_pulse_id_0 = 17'd11; pid_pulse_id_1 = 17'd22; pid_pulse_id_2 = 17'd33;
    pid_polynomial = 17'h00044; sys_ts = 24'h555555; pid_ready = 1'b1;
    lat = 0;
    while (!pid_reset && lat < 20) begin @(posedge clk_72MHz); #1; lat++; end
    checkOutput("wd_first_latency", lat, 3);
    width = 0;
    while (pid_reset && width < WATCHDOG_TICKS + 100) begin @(posedge clk_72MHz); #1; width++; end
    checkOutput("wd_high_cycles", width, WATCHDOG_TICKS - 1);
    checkOutput("wd_pid_reset_low", longint'(pid_reset), 0);
    exp_wd = 1;
    checkOutput("wd_flag", longint'(wd_error), STATS ? 1 : 0);
    sb.push_back({17'd11, 17'd22, 17'd33, 17'h00044, 24'h555555});
    exp_frame++;
    lat = 0;
    while (!pid_reset && lat < 20) begin @(posedge clk_72MHz); #1; lat++; end
    checkOutput("wd_recapture_latency", lat, 4);
    pid_ready = 1'b0;
    width = 0;
    while (pid_reset && width < 20) begin @(posedge clk_72MHz); #1; width++; end
    checkOutput("wd_recapture_width", width, 1);
    @(posedge clk_72MHz); #1;
    checkOutput("wd_level", longint'(fifo_level), 2);
    checkStats("wd");
    drainFifo();

    $display("[TB] reset during handshake");
    applyStimulus(17'd1, 17'd2, 17'd3, 17'd4, 24'h000001, 1'b0);
    applyStimulus(17'd5, 17'd6, 17'd7, 17'd8, 24'h000002, 1'b0);
    pid_ready = 1'b1;
    lat = 0;
    while (!pid_reset && lat < 20) begin @(posedge clk_72MHz); #1; lat++; end
    checkOutput("rst2_ack_seen", longint'(pid_reset), 1);
    reset = 1'b1;
    #1;
    sb.delete();
    exp_drop = 0; exp_frame = 0; exp_wd = 0;
    checkOutput("rst2_pid_reset", longint'(pid_reset), 0);
    checkOutput("rst2_valid", longint'(out_valid), 0);
    checkOutput("rst2_level", longint'(fifo_level), 0);
    checkStats("rst2");
    pid_ready = 1'b0;
    @(posedge clk_72MHz); #1;
    reset = 1'b0;
    @(posedge clk_72MHz); #1;

    $display("[TB] full FIFO with pop on detection edge");
    for (int i = 0; i < 4; i++)
      applyStimulus(17'(200 + i), 17'(300 + i), 17'(400 + i), 17'h10000 + 17'(i), 24'hB00000 + 24'(i), 1'b0);
    checkOutput("t6_full_level", longint'(fifo_level), 4);
    applyStimulus(17'd999, 17'd998, 17'd997, 17'h1FFFF, 24'hFFFFFF, 1'b1);
    checkOutput("t6_level", longint'(fifo_level), 3);
    checkOutput("t6_level_model", longint'(fifo_level), sb.size());
    checkStats("t6");
    drainFifo();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
